// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one `UART_LEN-bit word per write strobe, driven LSB first as 8N1.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit (8E1).
`ifndef UART_LEN
`define UART_LEN 8
`endif

module uart_tx_serializer #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [`UART_LEN-1:0] data_in,
    input  logic                 we,
    output logic                 data_out,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int LEN          = `UART_LEN;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_serializer: CLK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LEN-1:0]   shift_q, shift_d;
    logic             data_out_q, data_out_d;
    logic             busy_q, busy_d;
    logic             bit_end;
    logic [IDX_W-1:0] idx_next;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign idx_next = idx_q + IDX_W'(1);

    // data_out_d is the value the line takes at the coming edge, so every
    // bit change is decided one cycle ahead of where it appears.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (we) begin
                    shift_d    = data_in;
                    state_d    = S_START;
                    data_out_d = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    idx_d      = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d    = S_DATA;
                    data_out_d = shift_q[0];
                    idx_d      = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d    = S_PARITY;
                        data_out_d = ^shift_q;
`else
                        state_d    = S_STOP;
                        data_out_d = 1'b1;
`endif
                    end else begin
                        idx_d      = idx_next;
                        data_out_d = shift_q[idx_next];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    data_out_d = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                data_out_d = 1'b1;
                busy_d     = 1'b0;
                cnt_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_out_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;

endmodule
